// File: rtl/ex_stage_mc.sv
// EX stage with EX/MEM register, two-source operand forwarding and an iterative divider.
module ex_stage_mc #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned DIV_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            busywait,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [3:0]      op_i,
    input  logic            op1_sel_i,
    input  logic            op2_sel_i,
    input  logic [4:0]      rs1_label_i,
    input  logic [4:0]      rs2_label_i,
    input  logic [XLEN-1:0] rs1_value_i,
    input  logic [XLEN-1:0] rs2_value_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rd_i,
    input  logic            reg_wb_en_i,
    input  logic            memwb_valid_i,
    input  logic            memwb_wb_en_i,
    input  logic [4:0]      memwb_rd_i,
    input  logic [XLEN-1:0] memwb_data_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [XLEN-1:0] rs2_o,
    output logic [4:0]      rd_o,
    output logic            reg_wb_en_o
);

    localparam int unsigned SH_W  = $clog2(XLEN);
    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REM  = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;
    localparam logic [3:0] OP_PASS = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]  rs1_fwd_c, rs2_fwd_c, op1_c, op2_c, alu_c;
    logic [SH_W-1:0]  shamt_c;
    logic             is_div_c, is_signed_c, special_c, start_c;
    logic             a_neg_c, b_neg_c;
    logic [XLEN-1:0]  abs_a_c, abs_b_c;

    logic [XLEN-1:0]  div_quo_q, div_rem_q, div_dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q_q, neg_r_q, is_rem_q, div_wb_q;
    logic [4:0]       div_rd_q;

    logic [XLEN:0]    rem_sh_c;
    logic             ge_c;
    logic [XLEN-1:0]  rem_next_c, quo_next_c, div_res_c;

    // Operand forwarding: EX/MEM beats MEM/WB beats the register file.
    always_comb begin
        rs1_fwd_c = rs1_value_i;
        rs2_fwd_c = rs2_value_i;
        if (FWD_EN != 0) begin
            if (valid_o && reg_wb_en_o && rd_o != 5'd0 && rd_o == rs1_label_i)
                rs1_fwd_c = result_o;
            else if (memwb_valid_i && memwb_wb_en_i && memwb_rd_i != 5'd0 && memwb_rd_i == rs1_label_i)
                rs1_fwd_c = memwb_data_i;
            if (valid_o && reg_wb_en_o && rd_o != 5'd0 && rd_o == rs2_label_i)
                rs2_fwd_c = result_o;
            else if (memwb_valid_i && memwb_wb_en_i && memwb_rd_i != 5'd0 && memwb_rd_i == rs2_label_i)
                rs2_fwd_c = memwb_data_i;
        end
        op1_c   = op1_sel_i ? pc_i  : rs1_fwd_c;
        op2_c   = op2_sel_i ? imm_i : rs2_fwd_c;
        shamt_c = op2_c[SH_W-1:0];
    end

    // Single-cycle ALU; divide ops yield 0 here (used only when the divider is absent).
    always_comb begin
        alu_c = '0;
        case (op_i)
            OP_ADD:  alu_c = op1_c + op2_c;
            OP_SUB:  alu_c = op1_c - op2_c;
            OP_AND:  alu_c = op1_c & op2_c;
            OP_OR:   alu_c = op1_c | op2_c;
            OP_XOR:  alu_c = op1_c ^ op2_c;
            OP_SLL:  alu_c = op1_c << shamt_c;
            OP_SRL:  alu_c = op1_c >> shamt_c;
            OP_SRA:  alu_c = XLEN'($signed(op1_c) >>> shamt_c);
            OP_SLT:  alu_c = ($signed(op1_c) < $signed(op2_c)) ? XLEN'(1) : '0;
            OP_SLTU: alu_c = (op1_c < op2_c) ? XLEN'(1) : '0;
            OP_MUL:  alu_c = op1_c * op2_c;
            OP_PASS: alu_c = op2_c;
            default: alu_c = '0;
        endcase
    end

    // Divide start decode: sign handling and special-case detection.
    always_comb begin
        is_div_c    = (DIV_EN != 0) &&
                      (op_i == OP_DIV || op_i == OP_DIVU || op_i == OP_REM || op_i == OP_REMU);
        is_signed_c = (op_i == OP_DIV || op_i == OP_REM);
        a_neg_c     = is_signed_c && op1_c[XLEN-1];
        b_neg_c     = is_signed_c && op2_c[XLEN-1];
        abs_a_c     = a_neg_c ? (~op1_c + XLEN'(1)) : op1_c;
        abs_b_c     = b_neg_c ? (~op2_c + XLEN'(1)) : op2_c;
        special_c   = (op2_c == '0) || (is_signed_c && op1_c == MIN_NEG && op2_c == '1);
    end

    // One restoring-division step and the sign-corrected final result.
    always_comb begin
        rem_sh_c   = {div_rem_q, div_quo_q[XLEN-1]};
        ge_c       = rem_sh_c >= {1'b0, div_dvs_q};
        rem_next_c = ge_c ? (rem_sh_c[XLEN-1:0] - div_dvs_q) : rem_sh_c[XLEN-1:0];
        quo_next_c = {div_quo_q[XLEN-2:0], ge_c};
        if (is_rem_q)
            div_res_c = neg_r_q ? (~div_rem_q + XLEN'(1)) : div_rem_q;
        else
            div_res_c = neg_q_q ? (~div_quo_q + XLEN'(1)) : div_quo_q;
    end

    // Divider FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Divider FSM next state, stall and start strobe.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        start_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i && is_div_c && !flush_i) begin
                    start_c = 1'b1;
                    stall_o = 1'b1;
                    state_d = special_c ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                stall_o = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (!busywait) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // Divider operand/iteration registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_quo_q <= '0;
            div_rem_q <= '0;
            div_dvs_q <= '0;
            cnt_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            is_rem_q  <= 1'b0;
            div_wb_q  <= 1'b0;
            div_rd_q  <= '0;
        end else if (start_c) begin
            cnt_q     <= CNT_W'(XLEN);
            is_rem_q  <= (op_i == OP_REM || op_i == OP_REMU);
            div_wb_q  <= reg_wb_en_i;
            div_rd_q  <= rd_i;
            div_dvs_q <= abs_b_c;
            if (special_c) begin
                div_quo_q <= (op2_c == '0) ? '1 : op1_c;
                div_rem_q <= (op2_c == '0) ? op1_c : '0;
                neg_q_q   <= 1'b0;
                neg_r_q   <= 1'b0;
            end else begin
                div_quo_q <= abs_a_c;
                div_rem_q <= '0;
                neg_q_q   <= a_neg_c ^ b_neg_c;
                neg_r_q   <= a_neg_c;
            end
        end else if (state_q == S_RUN) begin
            div_quo_q <= quo_next_c;
            div_rem_q <= rem_next_c;
            cnt_q     <= cnt_q - CNT_W'(1);
        end
    end

    // EX/MEM pipeline register: flush bubbles, busywait holds, otherwise load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            result_o    <= '0;
            rs2_o       <= '0;
            rd_o        <= '0;
            reg_wb_en_o <= 1'b0;
        end else if (flush_i) begin
            valid_o     <= 1'b0;
            reg_wb_en_o <= 1'b0;
        end else if (!busywait) begin
            if (state_q == S_DONE) begin
                valid_o     <= 1'b1;
                result_o    <= div_res_c;
                rs2_o       <= rs2_fwd_c;
                rd_o        <= div_rd_q;
                reg_wb_en_o <= div_wb_q;
            end else if (stall_o) begin
                valid_o     <= 1'b0;
                reg_wb_en_o <= 1'b0;
            end else begin
                valid_o     <= valid_i;
                result_o    <= alu_c;
                rs2_o       <= rs2_fwd_c;
                rd_o        <= rd_i;
                reg_wb_en_o <= valid_i && reg_wb_en_i;
            end
        end
    end

endmodule
